branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Dynamic branch predictor plus branch target buffer (BTB) for the 5-stage WISC pipeline.
- Fetch looks up the current PC combinationally and gets a predicted direction and target.
- Decode, where the branch-control unit resolves direction and target, writes the outcome back, and the block flags a misprediction so the hazard unit can flush IF/ID and redirect the PC.
- Direct-mapped table; each entry holds a valid bit, a tag, a 2-bit saturating counter and a 16-bit target.

Parameters:
INDEX_BITS, 3, log2 of entry count (default 8 entries); index = PC[INDEX_BITS:1], tag = PC[15:INDEX_BITS+1]

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
enable  input  1  fetch not stalled; gates prediction output
PC_curr  input  16  fetch-stage PC to look up
predicted_taken  output  1  predict branch taken at PC_curr
predicted_target  output  16  predicted target for PC_curr
wen  input  1  decode holds a resolved branch (B or BR) and is not stalled
IF_ID_PC_curr  input  16  PC of the branch in decode
IF_ID_predicted_taken  input  1  prediction carried down the pipe with that branch
IF_ID_predicted_target  input  16  predicted target carried with that branch
actual_taken  input  1  resolved direction from branch control
actual_target  input  16  resolved target (PC_branch) from branch control
mispredicted  output  1  prediction wrong; flush and redirect

Behaviour:
- Reset (async, immediate): all valid=0, counters=2'b01, tags=0, targets=16'h0000.
  - Consequence: predicted_taken=0, predicted_target=16'h0000, and mispredicted follows its inputs (0 while wen=0).
- Counter encoding:
  - 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
  - Prediction is counter[1].
- Lookup (combinational, zero latency):
  - hit = valid[idx] & (tag[idx] == PC_curr tag field).
  - predicted_taken = enable & hit & counter[idx][1].
  - predicted_target = hit ? target[idx] : 16'h0000.
- Update (registered, at the clk edge when wen=1), using the index and tag of IF_ID_PC_curr:
  - Hit, actual_taken=1: counter increments, saturating at 11; target <= actual_target.
  - Hit, actual_taken=0: counter decrements, saturating at 00; target unchanged.
  - Miss, actual_taken=1: allocate or replace the entry: valid=1, tag written, counter=10, target=actual_target.
  - Miss, actual_taken=0: no change.
  - wen=0: no state change.
- mispredicted (combinational) = wen & ((actual_taken != IF_ID_predicted_taken) | (actual_taken & (IF_ID_predicted_target != actual_target))).
  - A not-taken branch with a matching not-taken prediction never flags, regardless of target.
- Same-cycle lookup and update of the same index: lookup returns the pre-update contents; the new contents are visible the cycle after the edge.
- Aliasing: a different tag at the same index is a miss; only a taken update replaces the entry.
- No internal pipelining. The IF_ID_* prediction fields are held by the pipeline registers, not by this block.
- rst asserted mid-operation clears the table immediately, and any in-flight update that cycle is lost.

Test Plan:
- Reset, PC_curr=0x0010, enable=1 -> predicted_taken=0, predicted_target=0x0000.
- wen=1, IF_ID_PC_curr=0x0010, actual_taken=1, actual_target=0x0040, IF_ID_predicted_taken=0 -> mispredicted=1 in the same cycle; next cycle PC_curr=0x0010 -> predicted_taken=1, target 0x0040 (counter 10).
- Then 2 not-taken updates at 0x0010 -> counter 10->01->00; predicted_taken=0 after the first; both update cycles flag mispredicted=1 when carrying predicted_taken=1.
- Saturation: 4 taken updates at 0x0010 -> counter 11; 1 not-taken update -> counter 10, still predicts taken.
- Alias: entry at 0x0010; lookup 0x0030 (same index 000, different tag) -> miss, 0/0x0000; taken update at 0x0030 to 0x0100 -> 0x0030 now hits, 0x0010 now misses.
- Target mismatch and same-index read/write:
  - Predicted taken to 0x0040, actual taken to 0x0050 -> mispredicted=1.
  - Concurrent lookup of the same PC that cycle shows 0x0040; next cycle it shows 0x0050.
  - rst pulse mid-sequence -> outputs 0 immediately.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor with BTB: combinational fetch lookup,
// decode-time update with 2-bit saturating counters, and misprediction flag.
module branch_predictor #(
    parameter int unsigned INDEX_BITS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] PC_curr,
    output logic        predicted_taken,
    output logic [15:0] predicted_target,
    input  logic        wen,
    input  logic [15:0] IF_ID_PC_curr,
    input  logic        IF_ID_predicted_taken,
    input  logic [15:0] IF_ID_predicted_target,
    input  logic        actual_taken,
    input  logic [15:0] actual_target,
    output logic        mispredicted
);

    localparam int unsigned ENTRIES = 1 << INDEX_BITS;
    localparam int unsigned TAG_W   = 15 - INDEX_BITS;

    logic                  r_valid [ENTRIES];
    logic [TAG_W-1:0]      r_tag   [ENTRIES];
    logic [1:0]            r_cnt   [ENTRIES];
    logic [15:0]           r_tgt   [ENTRIES];

    logic [INDEX_BITS-1:0] w_lk_idx;
    logic [TAG_W-1:0]      w_lk_tag;
    logic                  w_lk_hit;
    logic [INDEX_BITS-1:0] w_up_idx;
    logic [TAG_W-1:0]      w_up_tag;
    logic                  w_up_hit;
    logic [1:0]            w_up_cnt;
    logic [1:0]            w_cnt_next;
    logic                  w_unused_pc_lsbs;

    // Instructions are halfword aligned, so PC bit 0 never selects an entry.
    assign w_unused_pc_lsbs = PC_curr[0] ^ IF_ID_PC_curr[0];

    assign w_lk_idx = PC_curr[INDEX_BITS:1];
    assign w_lk_tag = PC_curr[15:INDEX_BITS+1];
    assign w_up_idx = IF_ID_PC_curr[INDEX_BITS:1];
    assign w_up_tag = IF_ID_PC_curr[15:INDEX_BITS+1];

    // Fetch lookup sees pre-update contents during a same-cycle write.
    assign w_lk_hit         = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign predicted_taken  = enable && w_lk_hit && r_cnt[w_lk_idx][1];
    assign predicted_target = w_lk_hit ? r_tgt[w_lk_idx] : 16'h0000;

    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_up_cnt = r_cnt[w_up_idx];

    always_comb begin
        w_cnt_next = w_up_cnt;
        if (actual_taken) begin
            if (w_up_cnt != 2'b11) w_cnt_next = w_up_cnt + 2'd1;
        end else begin
            if (w_up_cnt != 2'b00) w_cnt_next = w_up_cnt - 2'd1;
        end
    end

    assign mispredicted = wen && ((actual_taken != IF_ID_predicted_taken) ||
                                  (actual_taken && (IF_ID_predicted_target != actual_target)));

    // Table state; a taken miss allocates, a not-taken miss leaves the entry alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_tag[i]   <= '0;
                r_cnt[i]   <= 2'b01;
                r_tgt[i]   <= 16'h0000;
            end
        end else if (wen) begin
            if (w_up_hit) begin
                r_cnt[w_up_idx] <= w_cnt_next;
                if (actual_taken) r_tgt[w_up_idx] <= actual_target;
            end else if (actual_taken) begin
                r_valid[w_up_idx] <= 1'b1;
                r_tag[w_up_idx]   <= w_up_tag;
                r_cnt[w_up_idx]   <= 2'b10;
                r_tgt[w_up_idx]   <= actual_target;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: hand-computed lookup, update,
// saturation, aliasing, same-cycle read/write and reset expectations.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] PC_curr;
    logic        predicted_taken;
    logic [15:0] predicted_target;
    logic        wen;
    logic [15:0] IF_ID_PC_curr;
    logic        IF_ID_predicted_taken;
    logic [15:0] IF_ID_predicted_target;
    logic        actual_taken;
    logic [15:0] actual_target;
    logic        mispredicted;

    int n_checks = 0;
    int n_fail   = 0;

    branch_predictor #(.INDEX_BITS(3)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .enable                 (enable),
        .PC_curr                (PC_curr),
        .predicted_taken        (predicted_taken),
        .predicted_target       (predicted_target),
        .wen                    (wen),
        .IF_ID_PC_curr          (IF_ID_PC_curr),
        .IF_ID_predicted_taken  (IF_ID_predicted_taken),
        .IF_ID_predicted_target (IF_ID_predicted_target),
        .actual_taken           (actual_taken),
        .actual_target          (actual_target),
        .mispredicted           (mispredicted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic w, input logic [15:0] pc, input logic ipt,
                       input logic [15:0] iptgt, input logic at, input logic [15:0] atgt);
        wen                    = w;
        IF_ID_PC_curr          = pc;
        IF_ID_predicted_taken  = ipt;
        IF_ID_predicted_target = iptgt;
        actual_taken           = at;
        actual_target          = atgt;
        #1;
    endtask

    task automatic look(input string tag, input logic [15:0] pc, input logic exp_t,
                        input logic [15:0] exp_tgt);
        PC_curr = pc;
        #1;
        check({tag, "_taken"}, 16'(predicted_taken), 16'(exp_t));
        check({tag, "_target"}, predicted_target, exp_tgt);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; PC_curr = 16'h0010;
        upd(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        look("reset", 16'h0010, 1'b0, 16'h0000);
        check("reset_misp_idle", 16'(mispredicted), 16'd0);
        upd(1'b1, 16'h0010, 1'b0, 16'h0000, 1'b1, 16'h0040);
        check("reset_misp_follows", 16'(mispredicted), 16'd1);
        upd(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        tick();
        rst = 1'b0;
        tick();

        // First taken update allocates with counter 10; lookup still sees old state.
        upd(1'b1, 16'h0010, 1'b0, 16'h0000, 1'b1, 16'h0040);
        check("alloc_misp", 16'(mispredicted), 16'd1);
        look("alloc_pre", 16'h0010, 1'b0, 16'h0000);
        tick();
        upd(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        look("alloc_post", 16'h0010, 1'b1, 16'h0040);

        // Two not-taken: 10 -> 01 -> 00.
        upd(1'b1, 16'h0010, 1'b1, 16'h0040, 1'b0, 16'h0012);
        check("nt1_misp", 16'(mispredicted), 16'd1);
        tick();
        look("nt1_post", 16'h0010, 1'b0, 16'h0040);
        upd(1'b1, 16'h0010, 1'b1, 16'h0040, 1'b0, 16'h0012);
        check("nt2_misp", 16'(mispredicted), 16'd1);
        tick();
        look("nt2_post", 16'h0010, 1'b0, 16'h0040);
        // Not-taken predicted, not-taken actual, differing target: no flag; 00 stays 00.
        upd(1'b1, 16'h0010, 1'b0, 16'h0077, 1'b0, 16'h0012);
        check("nt_match_misp", 16'(mispredicted), 16'd0);
        tick();

        // Four taken: 00 -> 01 -> 10 -> 11 -> 11.
        upd(1'b1, 16'h0010, 1'b0, 16'h0000, 1'b1, 16'h0040);
        tick();
        look("tk1", 16'h0010, 1'b0, 16'h0040);
        tick();
        look("tk2", 16'h0010, 1'b1, 16'h0040);
        tick();
        tick();
        upd(1'b1, 16'h0010, 1'b1, 16'h0040, 1'b0, 16'h0000);
        tick();
        look("sat_nt1", 16'h0010, 1'b1, 16'h0040);
        tick();
        look("sat_nt2", 16'h0010, 1'b0, 16'h0040);
        upd(1'b1, 16'h0010, 1'b0, 16'h0000, 1'b1, 16'h0040);
        tick();
        upd(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        look("retaken", 16'h0010, 1'b1, 16'h0040);

        // Alias 0x0030 shares index 0 with 0x0010.
        look("alias_miss", 16'h0030, 1'b0, 16'h0000);
        upd(1'b1, 16'h0030, 1'b0, 16'h0000, 1'b0, 16'h0200);
        check("alias_nt_misp", 16'(mispredicted), 16'd0);
        tick();
        look("alias_nt_keep", 16'h0010, 1'b1, 16'h0040);
        upd(1'b1, 16'h0030, 1'b0, 16'h0000, 1'b1, 16'h0100);
        check("alias_tk_misp", 16'(mispredicted), 16'd1);
        tick();
        upd(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        look("alias_new", 16'h0030, 1'b1, 16'h0100);
        look("alias_old", 16'h0010, 1'b0, 16'h0000);

        // Reinstall 0x0010 then a taken branch to a new target.
        upd(1'b1, 16'h0010, 1'b0, 16'h0000, 1'b1, 16'h0040);
        tick();
        upd(1'b1, 16'h0010, 1'b1, 16'h0040, 1'b1, 16'h0050);
        check("tgt_misp", 16'(mispredicted), 16'd1);
        look("tgt_pre", 16'h0010, 1'b1, 16'h0040);
        tick();
        upd(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        look("tgt_post", 16'h0010, 1'b1, 16'h0050);
        upd(1'b1, 16'h0010, 1'b1, 16'h0050, 1'b1, 16'h0050);
        check("correct_misp", 16'(mispredicted), 16'd0);
        upd(1'b0, 16'h0010, 1'b1, 16'h0050, 1'b0, 16'h0000);
        check("wen0_misp", 16'(mispredicted), 16'd0);
        tick();
        look("wen0_keep", 16'h0010, 1'b1, 16'h0050);

        enable = 1'b0;
        look("disabled", 16'h0010, 1'b0, 16'h0050);
        enable = 1'b1;

        // Mid-cycle reset with a pending taken update at index 1.
        upd(1'b1, 16'h0002, 1'b0, 16'h0000, 1'b1, 16'h0300);
        rst = 1'b1;
        look("rst_mid", 16'h0010, 1'b0, 16'h0000);
        tick();
        rst = 1'b0;
        upd(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        tick();
        look("rst_lost_upd", 16'h0002, 1'b0, 16'h0000);
        look("rst_alias", 16'h0030, 1'b0, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
